regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file. It shares the file's single write port between two producers, the ALU result path and the memory load path, using valid/ready handshakes and a starvation-bounded priority scheme. Writes reach the file's RegWrite/WriteReg/WriteData inputs as registered signals. A 32-bit pending mask tracks destinations with an outstanding write, so the issue stage can detect RAW hazards.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (2**ADDR_W registers)
- STARVE_MAX, 3, consecutive lost cycles before the ALU requester is forced to win (1..15)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted this cycle
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load write-back request
- mem_ready  out  1  load request accepted this cycle
- mem_reg  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- issue_valid  in  1  instruction with a destination issued
- issue_reg  in  ADDR_W  destination of the issued instruction
- RegWrite  out  1  register-file write enable, registered
- WriteReg  out  ADDR_W  register-file write address, registered
- WriteData  out  DATA_W  register-file write data, registered
- pending  out  2**ADDR_W  bit i set means an outstanding write to register i

## Operation
- Handshake:
  - A transfer occurs when valid and ready are both high in the same cycle.
  - The requester holds valid, reg and data stable until accepted.
  - ready is combinational from state and the two valid inputs. It never depends on the requester's own ready.
  - At most one ready is high per cycle.
- Arbiter FSM, type arb_state_t:
  - PRIO_MEM:
    - mem wins when mem_valid is high. Otherwise alu wins when alu_valid is high.
    - starve_cnt increments in each cycle that alu_valid is high and alu loses.
    - When starve_cnt reaches STARVE_MAX, go to PRIO_ALU.
  - PRIO_ALU:
    - alu wins when alu_valid is high. Otherwise mem wins.
    - Return to PRIO_MEM after one alu grant, or when alu_valid is low.
  - starve_cnt clears on every alu grant and on entry to PRIO_MEM from PRIO_ALU.
- Write issue:
  - An accepted request with reg != 0 loads WriteReg/WriteData and sets RegWrite=1 in the next cycle.
  - An accepted request with reg == 0 is consumed and the next-cycle RegWrite is 0. This is a silent drop: register 0 is hardwired zero.
  - With no acceptance, RegWrite is 0 next cycle. WriteReg/WriteData hold their previous values.
- Scoreboard (pending):
  - issue_valid with issue_reg != 0 sets the bit at the next edge.
  - A cycle with RegWrite=1 clears bit WriteReg at that edge.
  - If a set and a clear hit the same register in the same cycle, the set wins because a newer producer exists.
  - issue_reg == 0 is ignored, so pending[0] is always 0.
  - A write to a register whose bit is already clear leaves the bit clear. This is not an error.

## Timing
- Reset (rst_n low at an edge):
  - RegWrite=0, WriteReg=0, WriteData=0, pending=0.
  - State PRIO_MEM, starve_cnt=0.
  - alu_ready and mem_ready are forced to 0 while rst_n is low.
- Write latency:
  - Accept in cycle N gives RegWrite high during N+1.
  - The register file captures the write at the end of N+1. A read returns the new value from N+2.
  - The pending bit is clear from N+2.
- Throughput: one write per cycle sustained. Back-to-back grants are allowed with no bubble.
- Issue latency: issue in cycle N makes the pending bit visible in N+1.
- Reset mid-operation: a write registered but not yet presented is discarded, and all pending bits clear. Requesters must re-present after reset.
- Same destination from both requesters in consecutive cycles: writes reach the file in grant order. The last grant determines the final value.

## Structure
- Package regfile_pkg:
  - ADDR_W, DATA_W and NUM_REGS = 2**ADDR_W
  - arb_state_t enum {PRIO_MEM, PRIO_ALU}
  - wb_req_t struct {reg, data}
- Sub-module wb_scoreboard: pending mask with set/clear ports and set-wins priority.
- The arbiter FSM and write register stay in the top module.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with both valid inputs high -> both readys 0, RegWrite=0, pending=0.
- Single ALU write: alu_valid with reg=5, data=0xDEADBEEF accepted in cycle N -> RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF in N+1. A read of register 5 returns 0xDEADBEEF in N+2.
- Contention and starvation: both valid continuously, STARVE_MAX=3 -> grant order mem, mem, mem, alu, mem, mem, mem, alu, and so on.
- Register 0: mem_valid with reg=0 -> mem_ready=1, RegWrite stays 0, pending[0]=0.
- Scoreboard: issue reg 7 in cycle N -> pending[7]=1 in N+1. A load write to 7 presented in cycle M with a new issue to 7 in the same cycle M -> pending[7] stays 1. A later write with no issue clears it.
- Reset mid-flight: accept an alu write to reg 9, then assert rst_n=0 in the next cycle -> RegWrite=0 after the edge and register 9 is unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and sizes for the register-file write-back path
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        PRIO_MEM = 1'b0,
        PRIO_ALU = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write mask; a same-cycle set beats a clear
module wb_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_set_en,
    input  logic [ADDR_W-1:0]    i_set_idx,
    input  logic                 i_clr_en,
    input  logic [ADDR_W-1:0]    i_clr_idx,
    output logic [2**ADDR_W-1:0] o_pending
);

    localparam int N = 2 ** ADDR_W;

    logic [N-1:0] r_pending;
    logic [N-1:0] w_set_mask;
    logic [N-1:0] w_clr_mask;
    logic [N-1:0] w_pending_nxt;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        // Register 0 is hardwired zero and never becomes pending.
        if (i_set_en && (i_set_idx != '0)) begin
            w_set_mask[i_set_idx] = 1'b1;
        end
        if (i_clr_en) begin
            w_clr_mask[i_clr_idx] = 1'b1;
        end
        w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between ALU and load paths
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_reg,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_reg,
    output logic                 RegWrite,
    output logic [ADDR_W-1:0]    WriteReg,
    output logic [DATA_W-1:0]    WriteData,
    output logic [2**ADDR_W-1:0] pending
);

    import regfile_pkg::*;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [3:0]        r_starve_cnt;
    logic [3:0]        w_starve_nxt;
    logic [3:0]        w_starve_inc;
    logic              w_alu_grant;
    logic              w_mem_grant;
    logic              w_accept;
    logic [ADDR_W-1:0] w_sel_reg;
    logic [DATA_W-1:0] w_sel_data;
    logic              r_we;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;

    assign w_starve_inc = r_starve_cnt + 4'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_alu_grant  = 1'b0;
        w_mem_grant  = 1'b0;
        if (rst_n) begin
            case (r_state)
                PRIO_MEM: begin
                    w_mem_grant = mem_valid;
                    w_alu_grant = alu_valid & ~mem_valid;
                    if (w_alu_grant) begin
                        w_starve_nxt = 4'd0;
                    end else if (alu_valid) begin
                        w_starve_nxt = w_starve_inc;
                        if (w_starve_inc == STARVE_LIM) begin
                            w_state_nxt = PRIO_ALU;
                        end
                    end
                end
                PRIO_ALU: begin
                    // One forced ALU slot at most; an absent ALU request also ends it.
                    w_alu_grant  = alu_valid;
                    w_mem_grant  = mem_valid & ~alu_valid;
                    w_state_nxt  = PRIO_MEM;
                    w_starve_nxt = 4'd0;
                end
                default: begin
                    w_state_nxt  = PRIO_MEM;
                    w_starve_nxt = 4'd0;
                end
            endcase
        end
    end

    assign alu_ready  = w_alu_grant;
    assign mem_ready  = w_mem_grant;
    assign w_accept   = w_alu_grant | w_mem_grant;
    assign w_sel_reg  = w_alu_grant ? alu_reg  : mem_reg;
    assign w_sel_data = w_alu_grant ? alu_data : mem_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= PRIO_MEM;
            r_starve_cnt <= 4'd0;
            r_we         <= 1'b0;
            r_wreg       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_we         <= w_accept && (w_sel_reg != '0);
            if (w_accept && (w_sel_reg != '0)) begin
                r_wreg  <= w_sel_reg;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign RegWrite  = r_we;
    assign WriteReg  = r_wreg;
    assign WriteData = r_wdata;

    wb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_set_en  (issue_valid),
        .i_set_idx (issue_reg),
        .i_clr_en  (r_we),
        .i_clr_idx (r_wreg),
        .o_pending (pending)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int SM = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_reg = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_reg = '0;
    logic [31:0] mem_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_reg = '0;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] pending;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .STARVE_MAX (SM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_reg     (alu_reg),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_reg     (mem_reg),
        .mem_data    (mem_data),
        .issue_valid (issue_valid),
        .issue_reg   (issue_reg),
        .RegWrite    (RegWrite),
        .WriteReg    (WriteReg),
        .WriteData   (WriteData),
        .pending     (pending)
    );

    // Register file fed by the DUT write port; ignores writes while in reset.
    logic        rf_clear = 1'b1;
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (RegWrite && rst_n && (WriteReg != 5'd0)) begin
            rf[WriteReg] <= WriteData;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Reference model: ALU wins over a waiting load only after SM counted losses.
    int          m_losses = 0;
    logic        m_we = 1'b0;
    logic [4:0]  m_wreg = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_pend = '0;
    logic        s_alu_rdy, s_mem_rdy;

    task automatic cycle();
        logic       ea, em;
        logic [4:0] r;
        #1;
        if (!rst_n) begin
            ea = 1'b0;
            em = 1'b0;
        end else begin
            ea = alu_valid && (!mem_valid || (m_losses >= SM));
            em = mem_valid && !ea;
        end
        s_alu_rdy = alu_ready;
        s_mem_rdy = mem_ready;
        check1("alu_ready", alu_ready, ea);
        check1("mem_ready", mem_ready, em);
        if (!rst_n) begin
            m_losses = 0;
            m_we     = 1'b0;
            m_wreg   = '0;
            m_wdata  = '0;
            m_pend   = '0;
        end else begin
            if (ea || ((m_losses >= SM) && !alu_valid)) m_losses = 0;
            else if (alu_valid) m_losses++;
            if (m_we) m_pend[m_wreg] = 1'b0;
            if (issue_valid && (issue_reg != 5'd0)) m_pend[issue_reg] = 1'b1;
            if (ea || em) begin
                r    = ea ? alu_reg : mem_reg;
                m_we = (r != 5'd0);
                if (r != 5'd0) begin
                    m_wreg  = r;
                    m_wdata = ea ? alu_data : mem_data;
                end
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check1("RegWrite", RegWrite, m_we);
        check("WriteReg", {27'b0, WriteReg}, {27'b0, m_wreg});
        check("WriteData", WriteData, m_wdata);
        check("pending", pending, m_pend);
    endtask

    typedef struct {
        logic       av;
        logic       mv;
        logic [4:0] ar;
        logic [4:0] mr;
        logic       era;
        logic       erm;
        logic       ewe;
        logic [4:0] ewreg;
    } vec_t;

    vec_t vecs [16];
    wb_req_t req;

    initial begin
        vecs[0]  = '{1, 1,  1,  2, 0, 1, 1,  2};
        vecs[1]  = '{1, 1,  1,  3, 0, 1, 1,  3};
        vecs[2]  = '{1, 1,  1,  4, 0, 1, 1,  4};
        vecs[3]  = '{1, 1,  1,  6, 1, 0, 1,  1};
        vecs[4]  = '{1, 1,  8, 10, 0, 1, 1, 10};
        vecs[5]  = '{1, 0,  8,  0, 1, 0, 1,  8};
        vecs[6]  = '{1, 1, 11, 12, 0, 1, 1, 12};
        vecs[7]  = '{0, 1,  0,  0, 0, 1, 0, 12};
        vecs[8]  = '{1, 1, 13, 14, 0, 1, 1, 14};
        vecs[9]  = '{1, 0, 13,  0, 1, 0, 1, 13};
        vecs[10] = '{0, 0,  0,  0, 0, 0, 0, 13};
        vecs[11] = '{1, 1, 15, 16, 0, 1, 1, 16};
        vecs[12] = '{1, 1, 15, 17, 0, 1, 1, 17};
        vecs[13] = '{1, 1, 15, 18, 0, 1, 1, 18};
        vecs[14] = '{0, 1,  0, 19, 0, 1, 1, 19};
        vecs[15] = '{1, 1, 20, 21, 0, 1, 1, 21};

        // Reset with both requesters asserting.
        rst_n = 1'b0;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        alu_reg = 5'd3;
        mem_reg = 5'd4;
        cycle();
        cycle();
        check1("rst_alu_ready", s_alu_rdy, 1'b0);
        check1("rst_mem_ready", s_mem_rdy, 1'b0);
        check1("rst_RegWrite", RegWrite, 1'b0);
        check("rst_pending", pending, 32'h0);
        rf_clear = 1'b0;
        rst_n = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;

        // Single ALU write and read-back two cycles later.
        alu_valid = 1'b1;
        alu_reg = 5'd5;
        alu_data = 32'hDEADBEEF;
        cycle();
        alu_valid = 1'b0;
        check1("alu_single_ready", s_alu_rdy, 1'b1);
        check1("alu_single_we", RegWrite, 1'b1);
        check("alu_single_wreg", {27'b0, WriteReg}, 32'd5);
        check("alu_single_wdata", WriteData, 32'hDEADBEEF);
        cycle();
        check("rf5_readback", rf[5], 32'hDEADBEEF);

        // Write to register 0 is consumed silently.
        mem_valid = 1'b1;
        mem_reg = 5'd0;
        mem_data = 32'h1234;
        cycle();
        mem_valid = 1'b0;
        check1("r0_mem_ready", s_mem_rdy, 1'b1);
        check1("r0_RegWrite", RegWrite, 1'b0);
        check1("r0_pending0", pending[0], 1'b0);

        // Scoreboard: set, set-beats-clear, later clear.
        issue_valid = 1'b1;
        issue_reg = 5'd7;
        cycle();
        issue_valid = 1'b0;
        check1("sb_set7", pending[7], 1'b1);
        mem_valid = 1'b1;
        mem_reg = 5'd7;
        mem_data = 32'h77;
        cycle();
        mem_valid = 1'b0;
        check1("sb_we7", RegWrite, 1'b1);
        issue_valid = 1'b1;
        issue_reg = 5'd7;
        cycle();
        issue_valid = 1'b0;
        check1("sb_set_wins", pending[7], 1'b1);
        mem_valid = 1'b1;
        mem_data = 32'h78;
        cycle();
        mem_valid = 1'b0;
        cycle();
        check1("sb_clear7", pending[7], 1'b0);
        check("rf7", rf[7], 32'h78);

        // Reset between acceptance and the write landing in the file.
        alu_valid = 1'b1;
        alu_reg = 5'd9;
        alu_data = 32'h99;
        issue_valid = 1'b1;
        issue_reg = 5'd9;
        cycle();
        alu_valid = 1'b0;
        issue_valid = 1'b0;
        check1("mid_we_before", RegWrite, 1'b1);
        rst_n = 1'b0;
        cycle();
        check1("mid_we_after", RegWrite, 1'b0);
        check("mid_pending", pending, 32'h0);
        check("mid_rf9", rf[9], 32'h0);

        // Arbitration table from a clean reset.
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alu_valid = vecs[i].av;
            mem_valid = vecs[i].mv;
            alu_reg   = vecs[i].ar;
            mem_reg   = vecs[i].mr;
            alu_data  = 32'hA000_0000 | i;
            mem_data  = 32'hB000_0000 | i;
            cycle();
            check1($sformatf("vec%0d_alu_ready", i), s_alu_rdy, vecs[i].era);
            check1($sformatf("vec%0d_mem_ready", i), s_mem_rdy, vecs[i].erm);
            check1($sformatf("vec%0d_we", i), RegWrite, vecs[i].ewe);
            check($sformatf("vec%0d_wreg", i), {27'b0, WriteReg}, {27'b0, vecs[i].ewreg});
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;

        // Randomized traffic with requesters holding until accepted.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if (!alu_valid && ($urandom_range(0, 99) < 60)) begin
                req = '{addr: 5'($urandom), data: $urandom};
                alu_valid = 1'b1;
                alu_reg   = req.addr;
                alu_data  = req.data;
            end
            if (!mem_valid && ($urandom_range(0, 99) < 60)) begin
                req = '{addr: 5'($urandom), data: $urandom};
                mem_valid = 1'b1;
                mem_reg   = req.addr;
                mem_data  = req.data;
            end
            issue_valid = ($urandom_range(0, 99) < 30);
            issue_reg   = 5'($urandom);
            cycle();
            if (s_alu_rdy) alu_valid = 1'b0;
            if (s_mem_rdy) mem_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
